om_map_writer: RTL and testbench

- Producer/responder end of the output-map (OM) memory interface consumed by the 17x17 max-value search.
- Accepts the detector's per-window 32-bit scores as a raster stream and writes them into an internal OM RAM at auto-incremented addresses.
- Signals frame completion on oFinish and serves consumer reads (iRd_OM/iAddr_OM) with fixed 1-cycle latency.
- Holds the map stable until the consumer releases it.

---
 rtl/om_pkg.sv | 20 ++
 rtl/om_ram.sv | 34 +++
 rtl/om_map_writer.sv | 140 ++++++++++++++
 tb/tb_om_map_writer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/om_pkg.sv
// Shared definitions for the output-map writer: default widths, FSM state
// encoding and the map-size helper.
package om_pkg;

   localparam int OM_ADDR_W = 13;
   localparam int OM_DATA_W = 32;

   // ST_CLEAR is only reachable when the clear-on-start sweep is compiled in.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DONE  = 2'd2,
      ST_CLEAR = 2'd3
   } om_state_e;

   function automatic int om_map_words(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/om_ram.sv
// OM storage: one write port, one registered read port, read-before-write.
// The read register resets to 0 and can be forced to 0 for out-of-range reads.
module om_ram
   import om_pkg::*;
#(
   parameter int DEPTH  = 3072,
   parameter int AW     = 12,
   parameter int DATA_W = OM_DATA_W
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iWe,
   input  logic [AW-1:0]     iWr_addr,
   input  logic [DATA_W-1:0] iWr_data,
   input  logic              iRd_en,
   input  logic              iRd_zero,
   input  logic [AW-1:0]     iRd_addr,
   output logic [DATA_W-1:0] oRd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; no reset so the array maps onto block RAM.
   always_ff @(posedge iClk) begin
      if (iWe) mem[iWr_addr] <= iWr_data;
   end

   // Registered read; sees the pre-write contents on a same-address collision.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset)      oRd_data <= '0;
      else if (iRd_en) oRd_data <= iRd_zero ? '0 : mem[iRd_addr];
   end

endmodule

// File: rtl/om_map_writer.sv
// Output-map writer: fills the OM RAM from a raster score stream, flags frame
// completion, holds the map until released and serves 1-cycle consumer reads.
// Optional OM_CLEAR_ON_START_EN: every start first zeroes the whole map.
module om_map_writer
   import om_pkg::*;
#(
   parameter int MAP_W  = 64,
   parameter int MAP_H  = 48,
   parameter int ADDR_W = OM_ADDR_W,
   parameter int DATA_W = OM_DATA_W
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iStart,
   input  logic              iWr_valid,
   input  logic [DATA_W-1:0] iWr_data,
   output logic              oWr_ready,
   input  logic              iRd_OM,
   input  logic [ADDR_W-1:0] iAddr_OM,
   output logic [DATA_W-1:0] oData_OM,
   output logic              oFinish,
   output logic              oMap_ready,
   input  logic              iRelease
);

   localparam int DEPTH = om_map_words(MAP_W, MAP_H);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
`ifdef OM_CLEAR_ON_START_EN
   localparam om_state_e START_ST = ST_CLEAR;
`else
   localparam om_state_e START_ST = ST_FILL;
`endif

   logic [1:0]        rst_sync;
   logic              rst;
   om_state_e         state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic              finish_n;
   logic              we;
   logic [DATA_W-1:0] wdata;
   logic              rd_zero;

   // Assert immediately, release after two clean iClk edges.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) rst_sync <= 2'b11;
      else        rst_sync <= {rst_sync[0], 1'b0};
   end
   assign rst = rst_sync[1];

   // FSM state, write pointer and the registered finish pulse.
   always_ff @(posedge iClk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         oFinish <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         oFinish <= finish_n;
      end
   end

   // Next state, pointer, RAM write strobe and level outputs.
   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      finish_n   = 1'b0;
      we         = 1'b0;
      wdata      = iWr_data;
      oWr_ready  = 1'b0;
      oMap_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (iStart) begin
               state_n = START_ST;
               ptr_n   = '0;
            end
         end
         ST_FILL: begin
            oWr_ready = 1'b1;
            if (iStart) begin
               // Restart wins over a word offered in the same cycle.
               state_n = START_ST;
               ptr_n   = '0;
            end else if (iWr_valid) begin
               we = 1'b1;
               if (ptr == LAST) begin
                  state_n  = ST_DONE;
                  finish_n = 1'b1;
               end else begin
                  ptr_n = ptr + 1'b1;
               end
            end
         end
         ST_DONE: begin
            oMap_ready = 1'b1;
            if (iRelease) begin
               state_n = iStart ? START_ST : ST_IDLE;
               ptr_n   = '0;
            end
         end
`ifdef OM_CLEAR_ON_START_EN
         ST_CLEAR: begin
            we    = 1'b1;
            wdata = '0;
            if (iStart) begin
               ptr_n = '0;
            end else if (ptr == LAST) begin
               state_n = ST_FILL;
               ptr_n   = '0;
            end else begin
               ptr_n = ptr + 1'b1;
            end
         end
`endif
         default: state_n = ST_IDLE;
      endcase
   end

   // Addresses beyond the map read back as zero.
   assign rd_zero = {1'b0, iAddr_OM} >= (ADDR_W + 1)'(DEPTH);

   om_ram #(
      .DEPTH  (DEPTH),
      .AW     (AW),
      .DATA_W (DATA_W)
   ) u_ram (
      .iClk     (iClk),
      .iReset   (rst),
      .iWe      (we),
      .iWr_addr (ptr[AW-1:0]),
      .iWr_data (wdata),
      .iRd_en   (iRd_OM),
      .iRd_zero (rd_zero),
      .iRd_addr (iAddr_OM[AW-1:0]),
      .oRd_data (oData_OM)
   );

endmodule

// File: tb/tb_om_map_writer.sv
// Bench for om_map_writer: read vectors from a table, streamed frames with a
// bench-side map model, reads checked through an expected-data queue.
module tb_om_map_writer;

   localparam int MW = 64, MH = 48, AW = 13, DW = 32, N = MW * MH;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] exp;
      string         nm;
   } rd_vec_t;

   logic          iClk = 1'b0, iReset = 1'b0, iStart = 1'b0, iWr_valid = 1'b0;
   logic          iRd_OM = 1'b0, iRelease = 1'b0;
   logic [DW-1:0] iWr_data = '0;
   logic [AW-1:0] iAddr_OM = '0;
   logic          oWr_ready, oFinish, oMap_ready;
   logic [DW-1:0] oData_OM;

   int            nvec = 0, nmis = 0;
   logic [DW-1:0] model [N];
   logic [DW-1:0] sb [$];
   rd_vec_t       tbl [7];

   om_map_writer #(.MAP_W(MW), .MAP_H(MH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .iClk(iClk), .iReset(iReset), .iStart(iStart), .iWr_valid(iWr_valid),
      .iWr_data(iWr_data), .oWr_ready(oWr_ready), .iRd_OM(iRd_OM),
      .iAddr_OM(iAddr_OM), .oData_OM(oData_OM), .oFinish(oFinish),
      .oMap_ready(oMap_ready), .iRelease(iRelease)
   );

   always #5 iClk = ~iClk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic sb_check(input string nm);
      if (sb.size() == 0) begin
         nvec++;
         nmis++;
         $display("FAIL %s: no expected entry queued", nm);
      end else begin
         chk(nm, oData_OM, sb.pop_front());
      end
   endtask

   task automatic model_clear;
`ifdef OM_CLEAR_ON_START_EN
      for (int i = 0; i < N; i++) model[i] = '0;
`endif
   endtask

   task automatic rd1(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string nm);
      iRd_OM   = 1'b1;
      iAddr_OM = addr;
      sb.push_back(exp);
      tick;
      iRd_OM = 1'b0;
      sb_check(nm);
   endtask

   task automatic readback(input string nm);
      for (int i = 0; i < N; i++) begin
         iRd_OM   = 1'b1;
         iAddr_OM = AW'(i);
         sb.push_back(model[i]);
         tick;
         sb_check(nm);
      end
      iRd_OM = 1'b0;
   endtask

   task automatic start_pulse;
      iStart = 1'b1;
      tick;
      iStart = 1'b0;
      model_clear();
   endtask

   // Offer words idx*mul+add until n are accepted; optionally read the word's
   // own address in the cycle it is written (rbw) to see the old contents.
   task automatic stream(input int n, input bit gaps, input int mul, input int add,
                         input int rbw, input bit expect_fin, input string nm);
      int idx = 0, cyc = 0, fin_cnt = 0;
      bit fin_ok = 1'b0, v, hs, rd;
      while (idx < n && cyc < 20000) begin
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         iWr_valid = v;
         iWr_data  = DW'(idx * mul + add);
         hs = v && oWr_ready;
         rd = hs && (idx == rbw);
         if (rd) begin
            iRd_OM   = 1'b1;
            iAddr_OM = AW'(idx);
            sb.push_back(model[idx]);
         end
         tick;
         iRd_OM = 1'b0;
         if (rd) sb_check({nm, " read-before-write"});
         if (hs) begin
            model[idx] = iWr_data;
            idx++;
         end
         if (oFinish) begin
            fin_cnt++;
            fin_ok = hs && (idx == N);
         end
         cyc++;
      end
      iWr_valid = 1'b0;
      chk({nm, " words accepted"}, idx, n);
      if (expect_fin) begin
         chk({nm, " finish count"}, fin_cnt, 1);
         chk({nm, " finish after last word"}, 32'(fin_ok), 1);
         chk({nm, " map_ready at finish"}, 32'(oMap_ready), 1);
         tick;
         chk({nm, " finish one cycle"}, 32'(oFinish), 0);
         chk({nm, " map_ready held"}, 32'(oMap_ready), 1);
      end else begin
         chk({nm, " no finish"}, fin_cnt, 0);
      end
   endtask

   initial begin
      tbl[0] = '{13'd0,    32'd0,    "rd addr 0"};
      tbl[1] = '{13'd1,    32'd3,    "rd addr 1"};
      tbl[2] = '{13'd3071, 32'd9213, "rd last addr"};
      tbl[3] = '{13'd3072, 32'd0,    "rd first out-of-range"};
      tbl[4] = '{13'd4000, 32'd0,    "rd addr 4000"};
      tbl[5] = '{13'd8191, 32'd0,    "rd max addr"};
      tbl[6] = '{13'd1000, 32'd3000, "rd addr 1000"};
      for (int i = 0; i < N; i++) model[i] = '0;

      // Reset values, then reset in the middle of a fill.
      #2 iReset = 1'b1;
      #1;
      chk("reset wr_ready", 32'(oWr_ready), 0);
      chk("reset finish", 32'(oFinish), 0);
      chk("reset map_ready", 32'(oMap_ready), 0);
      chk("reset data", oData_OM, 0);
      #20 iReset = 1'b0;
      repeat (3) tick;
      chk("idle wr_ready", 32'(oWr_ready), 0);
      start_pulse;
`ifndef OM_CLEAR_ON_START_EN
      chk("fill wr_ready after start", 32'(oWr_ready), 1);
`endif
      stream(100, 1'b0, 3, 0, -1, 1'b0, "T1");
      rd1(13'd5, 32'd15, "T1 read before reset");
      #2 iReset = 1'b1;
      #1;
      chk("mid-fill reset wr_ready", 32'(oWr_ready), 0);
      chk("mid-fill reset finish", 32'(oFinish), 0);
      chk("mid-fill reset map_ready", 32'(oMap_ready), 0);
      chk("mid-fill reset data", oData_OM, 0);
      #20 iReset = 1'b0;
      repeat (3) tick;
      chk("idle after reset release", 32'(oWr_ready), 0);

      // Full frame, no gaps, then the read vector table.
      start_pulse;
      stream(N, 1'b0, 3, 0, -1, 1'b1, "T2");
      for (int i = 0; i < 7; i++) rd1(tbl[i].addr, tbl[i].exp, tbl[i].nm);
      iAddr_OM = 13'd7;
      tick;
      chk("read data holds", oData_OM, 32'd3000);

      // Release and start together in DONE.
      iRelease = 1'b1;
      iStart   = 1'b1;
      tick;
      iRelease = 1'b0;
      iStart   = 1'b0;
      model_clear();
      chk("rel+start map_ready", 32'(oMap_ready), 0);
`ifndef OM_CLEAR_ON_START_EN
      chk("rel+start wr_ready", 32'(oWr_ready), 1);
`endif

      // Frame with random valid gaps, full readback, DONE ignores writes.
      stream(N, 1'b1, 5, 1, 10, 1'b1, "T3");
      readback("T3 readback");
      iWr_valid = 1'b1;
      iWr_data  = 32'hDEADBEEF;
      repeat (4) tick;
      iWr_valid = 1'b0;
      rd1(13'd0, model[0], "T3 DONE write ignored");
      chk("T3 map_ready held", 32'(oMap_ready), 1);

      // Release alone, then restart in the middle of a fill.
      iRelease = 1'b1;
      tick;
      iRelease = 1'b0;
      chk("release map_ready", 32'(oMap_ready), 0);
      chk("release to idle", 32'(oWr_ready), 0);
      start_pulse;
      stream(500, 1'b0, 7, 2, -1, 1'b0, "T4 partial");
      iRelease = 1'b1;
      tick;
      iRelease = 1'b0;
      chk("release in fill map_ready", 32'(oMap_ready), 0);
      chk("release in fill ignored", 32'(oWr_ready), 1);
      iStart    = 1'b1;
      iWr_valid = 1'b1;
      iWr_data  = 32'h00BADBAD;
      tick;
      iStart    = 1'b0;
      iWr_valid = 1'b0;
`ifndef OM_CLEAR_ON_START_EN
      rd1(13'd0, model[0], "T4 dropped word not at 0");
`endif
      model_clear();
      stream(N, 1'b0, 11, 3, -1, 1'b1, "T4");
      readback("T4 readback");

`ifdef OM_CLEAR_ON_START_EN
      // Clear sweep: oWr_ready low for one full map, zeros visible at the tail.
      begin
         int lowc = 0, k = 0;
         bit rdp = 1'b0;
         iRelease = 1'b1;
         iStart   = 1'b1;
         tick;
         iRelease = 1'b0;
         iStart   = 1'b0;
         while (!oWr_ready && k < 10000) begin
            if (lowc == 3000) begin
               iRd_OM   = 1'b1;
               iAddr_OM = 13'd10;
               sb.push_back(32'd0);
               rdp = 1'b1;
            end
            lowc++;
            tick;
            iRd_OM = 1'b0;
            if (rdp) begin
               sb_check("T6 read during clear");
               rdp = 1'b0;
            end
            k++;
         end
         chk("T6 clear cycles", lowc, N);
         chk("T6 fill after clear", 32'(oWr_ready), 1);
         chk("T6 map_ready low", 32'(oMap_ready), 0);
      end
`else
      // Without the sweep, unwritten locations keep the previous frame.
      iRelease = 1'b1;
      iStart   = 1'b1;
      tick;
      iRelease = 1'b0;
      iStart   = 1'b0;
      stream(1, 1'b0, 13, 4, -1, 1'b0, "T6 partial");
      rd1(13'd0, 32'd4, "T6 new word at 0");
      rd1(13'd5, model[5], "T6 old data kept");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
